dual_port_ram_fifo_controller: RTL and testbench
================================================

// Module: dual_port_ram_fifo_controller
// PURPOSE
//  Single-clock FIFO built around generic_dual_port_ram: owns the write and read pointers and
//  sequences RAM reads through its 1- or 2-cycle read latency. Exposes valid/ready streams on
//  both sides. A small prefetch (skid) buffer hides the latency so the read side sustains
//  one word per cycle. Used as the per-port packet/data buffer in the switch datapath.
// PARAMETERS
//  DATA_WIDTH        16    word width in bits
//  DATA_DEPTH        4096  RAM words; power of two, >= 4
//  PIPELINED_OUTPUT  1     passed to RAM; READ_LATENCY L = 1 + PIPELINED_OUTPUT
// PORTS
//  clock        in   1                     single clock; also drives both RAM clocks
//  reset_n      in   1                     asynchronous, active-low reset; drives both RAM resets
//  write_valid  in   1                     producer has a word
//  write_ready  out  1                     controller accepts the word this cycle
//  write_data   in   DATA_WIDTH            word to store
//  read_valid   out  1                     head word is on read_data
//  read_ready   in   1                     consumer takes the head word this cycle
//  read_data    out  DATA_WIDTH            head word; registered
//  fill_count   out  $clog2(DATA_DEPTH)+2  words held (RAM + in-flight + skid)
//  overflow     out  1                     sticky: write_valid while !write_ready
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers, counts, in-flight pipe and skid cleared.
//    Reset values: write_ready=1, read_valid=0, read_data=0, fill_count=0, overflow=0.
//  - Reset mid-operation discards all contents immediately. No partial word survives.
//  - Write accept: write_valid & write_ready. RAM write_enable=1, address=write_pointer.
//    write_pointer increments modulo DATA_DEPTH (natural wrap). ram_used +1.
//  - write_ready = (ram_used < DATA_DEPTH); registered count only, no same-cycle read credit.
//  - Read issue: ram_used != 0 and credit > 0. Present read_pointer to the RAM.
//    read_pointer increments modulo DATA_DEPTH. ram_used -1. Set bit 0 of inflight pipe.
//    credit = SKID_DEPTH - skid_count - inflight_count + (read_valid & read_ready).
//  - Simultaneous write accept and read issue: ram_used unchanged.
//  - A word is readable from RAM no earlier than the cycle after its write edge.
//    The RAM returns pre-write data for a same-edge address, and the registered ram_used
//    enforces this.
//  - Inflight pipe: L-bit shift register. When bit L-1 is set, RAM read_data is captured
//    into the skid tail at that edge.
//  - Skid buffer: SKID_DEPTH = L+1 entry register FIFO.
//    read_valid = (skid_count != 0); read_data = skid head.
//    Pop on read_valid & read_ready. Push and pop in the same cycle is legal.
//  - Credit rule guarantees no skid overrun. It sustains 1 word/cycle when the consumer
//    holds read_ready=1.
//  - First-word latency: accept at edge e0 gives read_valid high after edge e0+L+1.
//    That is 3 edges for PIPELINED_OUTPUT=1 and 2 edges for 0.
//  - Capacity: DATA_DEPTH + SKID_DEPTH words. write_ready drops only once RAM is full;
//    prefetch drains the RAM first.
//  - fill_count = ram_used + inflight_count + skid_count, registered, updated every edge.
//  - Empty: read_ready ignored, no state change. Full: write_valid ignored, overflow set,
//    data not written. overflow clears only on reset.
// STRUCTURE
//  - Package dual_port_ram_fifo_pkg holds:
//    function read_latency(pipelined) = 1+pipelined; function skid_depth(l) = l+1;
//    localparam width helpers for pointers and counts.
//  - One sub-module instance: generic_dual_port_ram. Clocks tied to clock, resets tied to reset_n.
//  - Skid buffer stays inline (small register array); no further sub-modules.
// TESTING (DATA_DEPTH=16 unless stated)
//  1. Reset, then single write 0xA5A5 at edge e0 with read_ready=0:
//     read_valid=1 and read_data=0xA5A5 after e0+3 (PIPELINED_OUTPUT=1), after e0+2 (=0).
//  2. Stream 0..99 with write_valid=1 and read_ready=1 every cycle:
//     outputs 0..99 in order, 1 word/cycle after fill; fill_count <= 3+1 in steady state.
//  3. read_ready=0, write 0,1,2,... until write_ready=0:
//     exactly 19 accepted (PIPELINED_OUTPUT=1), 18 (=0); fill_count=19/18.
//     Extra write sets overflow=1.
//  4. Drain case 3 with read_ready=1: values 0..18 in order, then read_valid=0,
//     fill_count=0, write_ready=1.
//  5. Random valid/ready at 50% each over 2000 words with pointer wrap:
//     scoreboard matches, no drop or duplicate, fill_count equals model every cycle.
//  6. Assert reset_n=0 mid-stream with 10 words held: outputs reset values immediately.
//     After release, one write of 0x1234 is the next word read.

Source files
------------

// File: rtl/dual_port_ram_fifo_pkg.sv
// Shared helpers for the RAM-backed FIFO controller: latency, skid sizing and width helpers.
package dual_port_ram_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_DATA_DEPTH = 4096;

    // RAM read latency in cycles: one for the array read, one more if the output is registered.
    function automatic int read_latency(input int pipelined);
        return 1 + pipelined;
    endfunction

    // Skid entries needed so a full in-flight pipe plus one held word never overruns.
    function automatic int skid_depth(input int l);
        return l + 1;
    endfunction

    function automatic int pointer_width(input int depth);
        return $clog2(depth);
    endfunction

    // ram_used must represent DATA_DEPTH itself, hence one extra bit.
    function automatic int used_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // fill_count covers DATA_DEPTH + skid + in-flight words.
    function automatic int fill_width(input int depth);
        return $clog2(depth) + 2;
    endfunction

endpackage

// File: rtl/dual_port_ram_fifo_controller_ram.sv
// Generic simple dual-port RAM: one write port, one read port, read-first on address collision,
// read latency of 1 or 2 cycles depending on PIPELINED_OUTPUT.
module generic_dual_port_ram #(
    parameter int DATA_WIDTH       = 16,
    parameter int DATA_DEPTH       = 4096,
    parameter int PIPELINED_OUTPUT = 1
) (
    input  logic                          clock_write,
    input  logic                          reset_n_write,
    input  logic                          write_enable,
    input  logic [$clog2(DATA_DEPTH)-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]         write_data,
    input  logic                          clock_read,
    input  logic                          reset_n_read,
    input  logic                          read_enable,
    input  logic [$clog2(DATA_DEPTH)-1:0] read_address,
    output logic [DATA_WIDTH-1:0]         read_data
);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] read_stage;

    // Array write; writes are suppressed while the write side is held in reset.
    always_ff @(posedge clock_write) begin
        if (write_enable && reset_n_write) begin
            mem[write_address] <= write_data;
        end
    end

    // First read stage; holds its value when no read is issued.
    always_ff @(posedge clock_read or negedge reset_n_read) begin
        if (!reset_n_read) begin
            read_stage <= '0;
        end else if (read_enable) begin
            read_stage <= mem[read_address];
        end
    end

    generate
        if (PIPELINED_OUTPUT != 0) begin : g_pipe
            logic [DATA_WIDTH-1:0] read_out;
            // Optional output register adding one cycle of latency.
            always_ff @(posedge clock_read or negedge reset_n_read) begin
                if (!reset_n_read) begin
                    read_out <= '0;
                end else begin
                    read_out <= read_stage;
                end
            end
            assign read_data = read_out;
        end else begin : g_direct
            assign read_data = read_stage;
        end
    endgenerate

endmodule

// File: rtl/dual_port_ram_fifo_controller.sv
// Single-clock FIFO around generic_dual_port_ram with a prefetch skid buffer that hides the
// RAM read latency so the read side sustains one word per cycle.
module dual_port_ram_fifo_controller
    import dual_port_ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
    parameter int DATA_DEPTH       = DEFAULT_DATA_DEPTH,
    parameter int PIPELINED_OUTPUT = 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          write_valid,
    output logic                          write_ready,
    input  logic [DATA_WIDTH-1:0]         write_data,
    output logic                          read_valid,
    input  logic                          read_ready,
    output logic [DATA_WIDTH-1:0]         read_data,
    output logic [$clog2(DATA_DEPTH)+1:0] fill_count,
    output logic                          overflow
);

    localparam int L    = read_latency(PIPELINED_OUTPUT);
    localparam int SKID = skid_depth(L);
    localparam int AW   = pointer_width(DATA_DEPTH);
    localparam int UW   = used_width(DATA_DEPTH);
    localparam int FW   = fill_width(DATA_DEPTH);
    localparam int SW   = $clog2(SKID + 1);

    logic [AW-1:0]         write_pointer;
    logic [AW-1:0]         read_pointer;
    logic [UW-1:0]         ram_used;
    logic [UW-1:0]         ram_used_next;
    logic [L-1:0]          inflight;
    logic [L-1:0]          inflight_next;
    logic [SW-1:0]         inflight_count;
    logic [SW-1:0]         inflight_count_next;
    logic [SW-1:0]         skid_count;
    logic [SW-1:0]         skid_count_next;
    logic [SW-1:0]         push_index;
    logic [DATA_WIDTH-1:0] skid_mem [SKID];
    logic [DATA_WIDTH-1:0] ram_read_data;
    logic                  write_accept;
    logic                  pop;
    logic                  capture;
    logic                  issue;
    int                    credit;

    // Full is judged on the registered count only; a same-cycle pop gives no write credit.
    assign write_ready  = (ram_used < UW'(DATA_DEPTH));
    assign read_valid   = (skid_count != '0);
    assign read_data    = skid_mem[0];
    assign write_accept = write_valid & write_ready;
    assign pop          = read_valid & read_ready;
    assign capture      = inflight[L-1];

    // Read issue decision and next-state counts; issue only while the skid can absorb the word.
    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < L; i++) begin
            inflight_count = inflight_count + SW'(inflight[i]);
        end
        credit = SKID - int'(skid_count) - int'(inflight_count) + int'(pop);
        issue  = (ram_used != '0) && (credit > 0);

        inflight_next    = inflight << 1;
        inflight_next[0] = issue;
        inflight_count_next = '0;
        for (int i = 0; i < L; i++) begin
            inflight_count_next = inflight_count_next + SW'(inflight_next[i]);
        end

        ram_used_next   = ram_used + UW'(write_accept) - UW'(issue);
        skid_count_next = skid_count + SW'(capture) - SW'(pop);
        push_index      = skid_count - SW'(pop);
    end

    // Pointers, occupancy, in-flight pipe, skid contents and status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_pointer <= '0;
            read_pointer  <= '0;
            ram_used      <= '0;
            inflight      <= '0;
            skid_count    <= '0;
            fill_count    <= '0;
            overflow      <= 1'b0;
            for (int i = 0; i < SKID; i++) begin
                skid_mem[i] <= '0;
            end
        end else begin
            if (write_accept) begin
                write_pointer <= write_pointer + 1'b1;
            end
            if (issue) begin
                read_pointer <= read_pointer + 1'b1;
            end
            ram_used   <= ram_used_next;
            inflight   <= inflight_next;
            skid_count <= skid_count_next;
            if (pop) begin
                for (int i = 0; i < SKID - 1; i++) begin
                    skid_mem[i] <= skid_mem[i+1];
                end
            end
            // Later assignment wins over the shift when the push lands on a shifted slot.
            if (capture) begin
                skid_mem[push_index] <= ram_read_data;
            end
            fill_count <= FW'(ram_used_next) + FW'(inflight_count_next) + FW'(skid_count_next);
            if (write_valid && !write_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    generic_dual_port_ram #(
        .DATA_WIDTH      (DATA_WIDTH),
        .DATA_DEPTH      (DATA_DEPTH),
        .PIPELINED_OUTPUT(PIPELINED_OUTPUT)
    ) u_ram (
        .clock_write  (clock),
        .reset_n_write(reset_n),
        .write_enable (write_accept),
        .write_address(write_pointer),
        .write_data   (write_data),
        .clock_read   (clock),
        .reset_n_read (reset_n),
        .read_enable  (issue),
        .read_address (read_pointer),
        .read_data    (ram_read_data)
    );

endmodule

// File: tb/tb_dual_port_ram_fifo_controller.sv
// Directed bench for dual_port_ram_fifo_controller (DATA_DEPTH=16, PIPELINED_OUTPUT=1).
module tb_dual_port_ram_fifo_controller;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int PIPE  = 1;
    localparam int LAT   = 1 + PIPE;
    localparam int SKIDN = LAT + 1;
    localparam int CAP   = DEPTH + SKIDN;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          write_valid;
    logic          write_ready;
    logic [DW-1:0] write_data;
    logic          read_valid;
    logic          read_ready;
    logic [DW-1:0] read_data;
    logic [5:0]    fill_count;
    logic          overflow;

    int            total = 0;
    int            bad   = 0;
    int            held  = 0;
    logic [DW-1:0] sbq [$];

    always #5 clock = ~clock;

    dual_port_ram_fifo_controller #(
        .DATA_WIDTH      (DW),
        .DATA_DEPTH      (DEPTH),
        .PIPELINED_OUTPUT(PIPE)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .write_valid(write_valid),
        .write_ready(write_ready),
        .write_data (write_data),
        .read_valid (read_valid),
        .read_ready (read_ready),
        .read_data  (read_data),
        .fill_count (fill_count),
        .overflow   (overflow)
    );

    // One clock: samples handshakes before the edge, updates the model after it.
    task automatic tick(output bit acc, output bit pop, output logic [DW-1:0] got,
                        output logic [DW-1:0] exp);
        logic [DW-1:0] wd;
        #2;
        acc = write_valid && write_ready;
        pop = read_valid && read_ready;
        got = read_data;
        wd  = write_data;
        exp = '0;
        @(posedge clock);
        #1;
        if (acc) begin
            sbq.push_back(wd);
            held++;
        end
        if (pop) begin
            if (sbq.size() != 0) exp = sbq.pop_front();
            held--;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; write_valid = 1'b0; read_ready = 1'b0; write_data = '0;
        #12;
        total++; if (write_ready !== 1'b1) begin bad++; $display("FAIL reset_write_ready got=%0b want=1", write_ready); end
        total++; if (read_valid !== 1'b0) begin bad++; $display("FAIL reset_read_valid got=%0b want=0", read_valid); end
        total++; if (read_data !== 16'h0) begin bad++; $display("FAIL reset_read_data got=%h want=0000", read_data); end
        total++; if (fill_count !== 6'd0) begin bad++; $display("FAIL reset_fill got=%0d want=0", fill_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
        reset_n = 1'b1;
        sbq.delete(); held = 0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_first_word();
        bit acc, pop;
        logic [DW-1:0] got, exp;
        write_valid = 1'b1; write_data = 16'hA5A5; read_ready = 1'b0;
        tick(acc, pop, got, exp);
        write_valid = 1'b0;
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL first_accept got=%0b want=1", acc); end
        for (int k = 1; k <= LAT + 1; k++) begin
            tick(acc, pop, got, exp);
            total++;
            if (read_valid !== 1'(k == LAT + 1)) begin
                bad++; $display("FAIL first_latency edge=e0+%0d got=%0b want=%0b", k, read_valid, (k == LAT + 1));
            end
        end
        total++; if (read_data !== 16'hA5A5) begin bad++; $display("FAIL first_data got=%h want=a5a5", read_data); end
        read_ready = 1'b1;
        tick(acc, pop, got, exp);
        read_ready = 1'b0;
        total++; if (!pop || got !== 16'hA5A5) begin bad++; $display("FAIL first_pop pop=%0b got=%h want=a5a5", pop, got); end
        total++; if (fill_count !== 6'd0 || read_valid !== 1'b0) begin bad++; $display("FAIL first_empty fill=%0d valid=%0b want=0/0", fill_count, read_valid); end
    endtask

    task automatic test_stream();
        bit acc, pop, started;
        logic [DW-1:0] got, exp;
        int nw, nr, cyc;
        nw = 0; nr = 0; cyc = 0; started = 0;
        read_ready = 1'b1;
        while (nr < 100 && cyc < 400) begin
            write_valid = (nw < 100);
            write_data  = 16'(nw);
            tick(acc, pop, got, exp);
            if (acc) nw++;
            if (started) begin
                total++; if (!pop) begin bad++; $display("FAIL stream_gap word=%0d got=no_pop want=pop", nr); end
            end
            if (pop) begin
                total++; if (got !== 16'(nr)) begin bad++; $display("FAIL stream_data got=%h want=%h", got, 16'(nr)); end
                nr++;
                started = 1;
            end
            total++; if (fill_count > 6'd4) begin bad++; $display("FAIL stream_fill got=%0d want<=4", fill_count); end
            cyc++;
        end
        write_valid = 1'b0; read_ready = 1'b0;
        total++; if (nr != 100) begin bad++; $display("FAIL stream_count got=%0d want=100", nr); end
    endtask

    task automatic test_full();
        bit acc, pop;
        logic [DW-1:0] got, exp;
        int n, cyc;
        n = 0; cyc = 0;
        read_ready = 1'b0;
        while (write_ready && cyc < 40) begin
            write_valid = 1'b1;
            write_data  = 16'(n);
            tick(acc, pop, got, exp);
            if (acc) n++;
            cyc++;
        end
        write_valid = 1'b0;
        tick(acc, pop, got, exp);
        total++; if (n != CAP) begin bad++; $display("FAIL full_accepted got=%0d want=%0d", n, CAP); end
        total++; if (fill_count !== 6'(CAP)) begin bad++; $display("FAIL full_fill got=%0d want=%0d", fill_count, CAP); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_overflow_early got=%0b want=0", overflow); end
        write_valid = 1'b1; write_data = 16'hFFFF;
        tick(acc, pop, got, exp);
        write_valid = 1'b0;
        total++; if (acc !== 1'b0) begin bad++; $display("FAIL full_extra_accept got=%0b want=0", acc); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_overflow got=%0b want=1", overflow); end
        total++; if (fill_count !== 6'(CAP)) begin bad++; $display("FAIL full_fill_after got=%0d want=%0d", fill_count, CAP); end
    endtask

    task automatic test_drain();
        bit acc, pop;
        logic [DW-1:0] got, exp;
        int n, cyc;
        n = 0; cyc = 0;
        read_ready = 1'b1; write_valid = 1'b0;
        while (n < CAP && cyc < 60) begin
            tick(acc, pop, got, exp);
            if (pop) begin
                total++; if (got !== 16'(n)) begin bad++; $display("FAIL drain_data got=%h want=%h", got, 16'(n)); end
                n++;
            end
            cyc++;
        end
        read_ready = 1'b0;
        total++; if (n != CAP) begin bad++; $display("FAIL drain_count got=%0d want=%0d", n, CAP); end
        total++; if (read_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%0b want=0", read_valid); end
        total++; if (fill_count !== 6'd0) begin bad++; $display("FAIL drain_fill got=%0d want=0", fill_count); end
        total++; if (write_ready !== 1'b1) begin bad++; $display("FAIL drain_write_ready got=%0b want=1", write_ready); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL drain_overflow_sticky got=%0b want=1", overflow); end
    endtask

    task automatic test_random();
        bit acc, pop;
        logic [DW-1:0] got, exp;
        int n_acc, cyc;
        n_acc = 0; cyc = 0;
        while (n_acc < 2000 && cyc < 20000) begin
            write_valid = 1'($urandom_range(0, 1));
            write_data  = 16'($urandom);
            read_ready  = 1'($urandom_range(0, 1));
            tick(acc, pop, got, exp);
            if (acc) n_acc++;
            if (pop) begin
                total++; if (got !== exp) begin bad++; $display("FAIL random_data got=%h want=%h", got, exp); end
            end
            total++; if (fill_count !== 6'(held)) begin bad++; $display("FAIL random_fill got=%0d want=%0d", fill_count, held); end
            cyc++;
        end
        write_valid = 1'b0; read_ready = 1'b1;
        cyc = 0;
        while (held > 0 && cyc < 100) begin
            tick(acc, pop, got, exp);
            if (pop) begin
                total++; if (got !== exp) begin bad++; $display("FAIL random_drain_data got=%h want=%h", got, exp); end
            end
            cyc++;
        end
        read_ready = 1'b0;
        total++; if (n_acc != 2000) begin bad++; $display("FAIL random_accepted got=%0d want=2000", n_acc); end
        total++; if (held != 0 || read_valid !== 1'b0 || fill_count !== 6'd0) begin
            bad++; $display("FAIL random_empty held=%0d valid=%0b fill=%0d want=0/0/0", held, read_valid, fill_count);
        end
    endtask

    task automatic test_mid_reset();
        bit acc, pop, seen;
        logic [DW-1:0] got, exp;
        int cyc;
        read_ready = 1'b0; write_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            write_data = 16'(16'h0100 + i);
            tick(acc, pop, got, exp);
        end
        write_valid = 1'b0;
        tick(acc, pop, got, exp);
        tick(acc, pop, got, exp);
        total++; if (fill_count !== 6'd10) begin bad++; $display("FAIL midrst_held got=%0d want=10", fill_count); end
        reset_n = 1'b0;
        #1;
        total++; if (write_ready !== 1'b1) begin bad++; $display("FAIL midrst_write_ready got=%0b want=1", write_ready); end
        total++; if (read_valid !== 1'b0) begin bad++; $display("FAIL midrst_read_valid got=%0b want=0", read_valid); end
        total++; if (read_data !== 16'h0) begin bad++; $display("FAIL midrst_read_data got=%h want=0000", read_data); end
        total++; if (fill_count !== 6'd0) begin bad++; $display("FAIL midrst_fill got=%0d want=0", fill_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL midrst_overflow got=%0b want=0", overflow); end
        sbq.delete(); held = 0;
        #3;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        write_valid = 1'b1; write_data = 16'h1234;
        tick(acc, pop, got, exp);
        write_valid = 1'b0; read_ready = 1'b1;
        seen = 0; cyc = 0;
        while (!seen && cyc < 10) begin
            tick(acc, pop, got, exp);
            if (pop) begin
                seen = 1;
                total++; if (got !== 16'h1234) begin bad++; $display("FAIL midrst_first_word got=%h want=1234", got); end
            end
            cyc++;
        end
        read_ready = 1'b0;
        total++; if (!seen) begin bad++; $display("FAIL midrst_timeout got=no_word want=1234"); end
        total++; if (read_valid !== 1'b0 || fill_count !== 6'd0) begin
            bad++; $display("FAIL midrst_after valid=%0b fill=%0d want=0/0", read_valid, fill_count);
        end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_stream();
        test_full();
        test_drain();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
